// File: rtl/bless_pkg.sv
// Shared BLESS flit definitions: header field layout, widths and coordinate types.
package bless_pkg;
  localparam int FLIT_W  = 13;
  localparam int AGE_MAX = 15;
  localparam int AGE_W   = 4;
  localparam int V_BIT   = 12;
  localparam int SRC_HI  = 11;
  localparam int SRC_LO  = 8;
  localparam int DST_HI  = 7;
  localparam int DST_LO  = 4;
  localparam int AGE_HI  = 3;
  localparam int AGE_LO  = 0;

  typedef logic [1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } node_t;

  typedef struct packed {
    node_t src;
    node_t dst;
  } hdr_t;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    return (age == AGE_W'(AGE_MAX)) ? age : age + AGE_W'(1);
  endfunction
endpackage

// File: rtl/inj_fifo.sv
// Circular header queue for the injection port; with BLESS_INJ_AGE_EN each slot
// carries a saturating age that advances on every prescaler tick.
module inj_fifo
  import bless_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
`ifdef BLESS_INJ_AGE_EN
  input  logic                         tick,
  output logic [AGE_W-1:0]             head_age,
`endif
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTRW = $clog2(DEPTH);

  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [W-1:0]    data_q [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload needs no reset: the top masks the head while the queue is empty.
  always_ff @(posedge clock) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

  assign head_data = data_q[rd_ptr];

`ifdef BLESS_INJ_AGE_EN
  logic [AGE_W-1:0] age_q [DEPTH];

  // A slot written this cycle starts at 0 even on a tick; a popped head
  // leaves with the age it showed, since the tick lands only at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PTRW'(i))) age_q[i] <= '0;
        else if (tick)                    age_q[i] <= age_inc(age_q[i]);
      end
    end
  end

  assign head_age = age_q[rd_ptr];
`endif
endmodule

// File: rtl/bless_flit_inject.sv
// BLESS injection queue: checks local requests, builds {valid,src,dst,age} headers
// and presents the oldest one to the router. Aging is enabled by BLESS_INJ_AGE_EN.
module bless_flit_inject
  import bless_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int AGE_PERIOD = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [1:0]                   addrx,
  input  logic [1:0]                   addry,
  input  logic [1:0]                   addrx_max,
  input  logic [1:0]                   addry_max,
  input  logic                         req_valid,
  input  logic [1:0]                   req_dstx,
  input  logic [1:0]                   req_dsty,
  output logic                         req_ready,
  output logic                         req_err,
  output logic [FLIT_W-1:0]            inj_flit,
  input  logic                         inj_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int CW = $clog2(DEPTH+1);

  node_t            own;
  node_t            dst;
  hdr_t             push_hdr;
  hdr_t             head_hdr;
  logic [AGE_W-1:0] head_age;
  logic             handshake;
  logic             bad_dst;
  logic             push;
  logic             pop;
  logic             occupied;

  assign own       = '{x: addrx, y: addry};
  assign dst       = '{x: req_dstx, y: req_dsty};
  assign push_hdr  = '{src: own, dst: dst};

  assign occupied  = (level != '0);
  assign req_ready = (level < CW'(DEPTH));
  assign handshake = req_valid && req_ready;
  assign bad_dst   = (dst == own) || (req_dstx > addrx_max) || (req_dsty > addry_max);
  assign push      = handshake && !bad_dst;
  assign pop       = occupied && inj_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) req_err <= 1'b0;
    else          req_err <= handshake && bad_dst;
  end

`ifdef BLESS_INJ_AGE_EN
  localparam int PW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(AGE_PERIOD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (AGE_PERIOD == 0);
  assign head_age   = '0;
`endif

  inj_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(hdr_t))
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_hdr),
    .pop       (pop),
`ifdef BLESS_INJ_AGE_EN
    .tick      (tick),
    .head_age  (head_age),
`endif
    .head_data (head_hdr),
    .count     (level)
  );

  always_comb begin
    inj_flit = '0;
    if (occupied) begin
      inj_flit[V_BIT]           = 1'b1;
      inj_flit[SRC_HI:SRC_LO]   = head_hdr.src;
      inj_flit[DST_HI:DST_LO]   = head_hdr.dst;
      inj_flit[AGE_HI:AGE_LO]   = head_age;
    end
  end
endmodule

// File: tb/tb_bless_flit_inject.sv
// Bench for bless_flit_inject: vector table, directed corner sequences and a
// random run against a queue-based reference model.
`timescale 1ns/1ps
module tb_bless_flit_inject;
  localparam int DEPTH      = 4;
  localparam int AGE_PERIOD = 8;
`ifdef BLESS_INJ_AGE_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addrx = 2'b01, addry = 2'b01, addrx_max = 2'b11, addry_max = 2'b11;
  logic        req_valid = 1'b0;
  logic [1:0]  req_dstx = '0, req_dsty = '0;
  logic        inj_ready = 1'b0;
  logic        req_ready, req_err;
  logic [12:0] inj_flit;
  logic [2:0]  level;

  bless_flit_inject #(.DEPTH(DEPTH), .AGE_PERIOD(AGE_PERIOD)) dut (
    .clock(clock), .reset_n(reset_n), .addrx(addrx), .addry(addry),
    .addrx_max(addrx_max), .addry_max(addry_max), .req_valid(req_valid),
    .req_dstx(req_dstx), .req_dsty(req_dsty), .req_ready(req_ready),
    .req_err(req_err), .inj_flit(inj_flit), .inj_ready(inj_ready), .level(level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    int         age;
  } ent_t;

  ent_t mq[$];
  int   m_pre;
  bit   m_err;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] model_flit();
    if (mq.size() == 0) return 13'h0;
    return {1'b1, mq[0].src, mq[0].dst, 4'(mq[0].age)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pre = 0;
    m_err = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [1:0] dx, input logic [1:0] dy, input logic ir);
    req_valid = v;
    req_dstx  = dx;
    req_dsty  = dy;
    inj_ready = ir;
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic cycle();
    bit ready, bad, acc, pop, tick;
    ready = (mq.size() < DEPTH);
    bad   = ({req_dstx, req_dsty} == {addrx, addry}) || (req_dstx > addrx_max) ||
            (req_dsty > addry_max);
    acc   = req_valid && ready && !bad;
    m_err = req_valid && ready && bad;
    pop   = (mq.size() != 0) && inj_ready;
    tick  = AGING && (m_pre == AGE_PERIOD - 1);
    if (pop) void'(mq.pop_front());
    if (tick) foreach (mq[i]) if (mq[i].age < 15) mq[i].age = mq[i].age + 1;
    if (acc) mq.push_back('{src: {addrx, addry}, dst: {req_dstx, req_dsty}, age: 0});
    m_pre = (m_pre + 1) % AGE_PERIOD;
    @(posedge clock);
    #1;
    chk("model_flit",  inj_flit,  model_flit());
    chk("model_level", level,     mq.size());
    chk("model_ready", req_ready, (mq.size() < DEPTH));
    chk("model_err",   req_err,   m_err);
  endtask

  task automatic reset_check(input string tag);
    #2;
    reset_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    #1;
    chk({tag, "_flit"},  inj_flit,  13'h0);
    chk({tag, "_level"}, level,     3'd0);
    chk({tag, "_ready"}, req_ready, 1'b1);
    chk({tag, "_err"},   req_err,   1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  dx, dy, xmax, ymax;
    logic        err;
    logic [2:0]  lvl;
    logic [12:0] flit;
  } vec_t;

  vec_t       vt[8];
  logic [3:0] exp_dst[4];

  initial begin
    vt[0] = '{dx: 2'd0, dy: 2'd1, xmax: 2'd3, ymax: 2'd3, err: 1'b0, lvl: 3'd1, flit: 13'h1510};
    vt[1] = '{dx: 2'd1, dy: 2'd1, xmax: 2'd3, ymax: 2'd3, err: 1'b1, lvl: 3'd0, flit: 13'h0000};
    vt[2] = '{dx: 2'd3, dy: 2'd0, xmax: 2'd2, ymax: 2'd3, err: 1'b1, lvl: 3'd0, flit: 13'h0000};
    vt[3] = '{dx: 2'd3, dy: 2'd3, xmax: 2'd3, ymax: 2'd3, err: 1'b0, lvl: 3'd1, flit: 13'h15F0};
    vt[4] = '{dx: 2'd0, dy: 2'd3, xmax: 2'd3, ymax: 2'd2, err: 1'b1, lvl: 3'd0, flit: 13'h0000};
    vt[5] = '{dx: 2'd2, dy: 2'd2, xmax: 2'd2, ymax: 2'd2, err: 1'b0, lvl: 3'd1, flit: 13'h15A0};
    vt[6] = '{dx: 2'd0, dy: 2'd0, xmax: 2'd3, ymax: 2'd3, err: 1'b0, lvl: 3'd1, flit: 13'h1500};
    vt[7] = '{dx: 2'd1, dy: 2'd0, xmax: 2'd1, ymax: 2'd0, err: 1'b0, lvl: 3'd1, flit: 13'h1540};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_flit",  inj_flit,  13'h0);
    chk("rst_level", level,     3'd0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_err",   req_err,   1'b0);
    reset_n = 1'b1;

    // Single requests from an empty queue, drained the following cycle.
    for (int i = 0; i < 8; i++) begin
      addrx_max = vt[i].xmax;
      addry_max = vt[i].ymax;
      drive(1'b1, vt[i].dx, vt[i].dy, 1'b1);
      cycle();
      chk("vec_err",   req_err,  vt[i].err);
      chk("vec_flit",  inj_flit, vt[i].flit);
      chk("vec_level", level,    vt[i].lvl);
      drive(1'b0, 2'd0, 2'd0, 1'b1);
      cycle();
      chk("vec_drain", inj_flit, 13'h0);
      chk("vec_noerr", req_err,  1'b0);
    end
    addrx_max = 2'b11;
    addry_max = 2'b11;

    // Fill to full, refuse a fifth, then drain in order.
    exp_dst[0] = 4'b0000; exp_dst[1] = 4'b0100; exp_dst[2] = 4'b1101; exp_dst[3] = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, exp_dst[k][3:2], exp_dst[k][1:0], 1'b0);
      cycle();
    end
    chk("full_ready", req_ready, 1'b0);
    chk("full_level", level,     3'd4);
    drive(1'b1, 2'd2, 2'd2, 1'b0);
    cycle();
    chk("full_refuse_level", level,   3'd4);
    chk("full_refuse_err",   req_err, 1'b0);
    drive(1'b0, 2'd0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("order_dst", inj_flit[7:4], exp_dst[k]);
      cycle();
    end
    chk("order_empty", level, 3'd0);

    // Simultaneous enqueue and dequeue at level 2.
    drive(1'b1, 2'd0, 2'd0, 1'b0); cycle();
    drive(1'b1, 2'd2, 2'd3, 1'b0); cycle();
    drive(1'b1, 2'd3, 2'd2, 1'b1); cycle();
    chk("simul_level", level, 3'd2);
    drive(1'b0, 2'd0, 2'd0, 1'b1);
    chk("simul_head", inj_flit[7:4], 4'b1011);
    cycle();
    chk("simul_tail", inj_flit[7:4], 4'b1110);
    cycle();
    chk("simul_empty", level, 3'd0);

    // Aging: one resident flit held for 16 then 200 cycles.
    drive(1'b1, 2'd0, 2'd0, 1'b0); cycle();
    drive(1'b0, 2'd0, 2'd0, 1'b0);
    repeat (16) cycle();
    chk("age_16", inj_flit[3:0], AGING ? 4'd2 : 4'd0);
    repeat (184) cycle();
    chk("age_200", inj_flit[3:0], AGING ? 4'd15 : 4'd0);
    drive(1'b0, 2'd0, 2'd0, 1'b1); cycle();

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'(k), 2'd3, 1'b0);
      cycle();
    end
    reset_check("midrst");

    // Random traffic with occasional address and bound changes.
    for (int n = 0; n < 3000; n++) begin
      if ((n % 300) == 0) begin
        addrx     = 2'($urandom_range(0, 3));
        addry     = 2'($urandom_range(0, 3));
        addrx_max = 2'($urandom_range(1, 3));
        addry_max = 2'($urandom_range(1, 3));
      end
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 4));
      cycle();
    end
    reset_check("endrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bless_flit_inject.md
# bless_flit_inject

Per-node injection queue for the BLESS bufferless router. It accepts local packet requests (destination coordinates) and builds 13-bit header flits in the router's format `{valid, src, dst, age}`. It holds them in a small FIFO and presents the oldest one on the router's injection port until the router grants a free output. It is the producer side of the header consumed by the router's route-compute stage.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AGE_PERIOD`, 8: cycles per age increment; ≥1.

Ports:
- `clock`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `addrx`, in, 2: this node's X coordinate.
- `addry`, in, 2: this node's Y coordinate.
- `addrx_max`, in, 2: largest legal X in the mesh.
- `addry_max`, in, 2: largest legal Y in the mesh.
- `req_valid`, in, 1: local injection request.
- `req_dstx`, in, 2: destination X.
- `req_dsty`, in, 2: destination Y.
- `req_ready`, out, 1: queue can accept (`level < DEPTH`).
- `req_err`, out, 1: one-cycle pulse; the request was rejected.
- `inj_flit`, out, 13: `[12]` valid, `[11:10]` src X, `[9:8]` src Y, `[7:6]` dst X, `[5:4]` dst Y, `[3:0]` age.
- `inj_ready`, in, 1: router takes `inj_flit` this cycle.
- `level`, out, `$clog2(DEPTH+1)`: occupancy.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready`.
  - Valid requests are enqueued with src = `{addrx,addry}`, dst = `{req_dstx,req_dsty}` and age 0.
- **Reject (no enqueue, `req_err` = 1 next cycle):** any of the following.
  - Destination equals own address.
  - `req_dstx > addrx_max`.
  - `req_dsty > addry_max`.
- **Dequeue:** occurs when `inj_flit[12] && inj_ready`. The head is removed and the next entry appears.
- `inj_flit[12]` = (`level != 0`). When empty, `inj_flit` = 13'h0000.
- **Order:** strict FIFO; no reordering or bypass.
- **Simultaneous enqueue and dequeue:** both take effect; `level` is unchanged.
  - This is allowed at full only if `req_ready` was 1; it is not, so a full queue accepts nothing that cycle.
- **Aging:**
  - A prescaler counts `0..AGE_PERIOD-1` and wraps. The wrap cycle is the tick.
  - On a tick, every resident entry increments age, saturating at 15.
  - An entry enqueued on the tick cycle gets age 0.
  - An entry dequeued on the tick cycle leaves with its pre-tick age.
- `addrx`/`addry` are sampled at enqueue. Later changes do not alter queued src fields.

## Timing
- **Reset values:** `inj_flit` = 0, `req_ready` = 1, `req_err` = 0, `level` = 0, prescaler = 0.
- **Reset mid-operation:** all entries are dropped immediately, asynchronously.
- **Enqueue latency:** a request accepted at edge t is visible on `inj_flit` after edge t if the queue was empty; otherwise it appears behind older entries.
- **Registered outputs:** `inj_flit` and `req_err` are driven from registers. `req_ready` and `level` derive from the registered count.
- **Throughput:** one enqueue and one dequeue per cycle.

## Configuration
- **`BLESS_INJ_AGE_EN` defined:** aging in the queue as above.
- **Undefined:**
  - Prescaler and per-entry age increment logic are removed.
  - Age field is constant 4'b0000 on every flit.
  - All other behaviour is identical.

## Structure
- **Shared package `bless_pkg`:**
  - `FLIT_W` = 13 and `AGE_MAX` = 15.
  - Field positions: `V_BIT`, `SRC_HI/LO`, `DST_HI/LO`, `AGE_HI/LO`.
  - Coordinate type of 2 bits.
- **Sub-module `inj_fifo`:** circular buffer with rd/wr pointers, count, and parallel saturating age update on tick.
- **Top level:** header assembly, destination checks, prescaler, error pulse.

## Test plan
All scenarios use `addrx` = 01, `addry` = 01, max = 11/11, `DEPTH` = 4, `AGE_PERIOD` = 8, unless stated.

1. Assert `reset_n` = 0 mid-traffic -> `inj_flit` = 13'h0000, `level` = 0, `req_ready` = 1 immediately.
2. Request dst (0,1) with `inj_ready` = 1 -> next cycle `inj_flit` = 13'b1_0101_0001_0000; empty the following cycle.
3. Request dst (1,1) -> `req_err` pulse, `level` stays 0. With `addrx_max` = 10, request dst (3,0) -> `req_err` pulse.
4. `inj_ready` = 0, enqueue dsts 0000, 0100, 1101, 0011 -> `req_ready` = 0, `level` = 4, and a fifth request is not accepted. Then set `inj_ready` = 1 -> dsts emerge in order on consecutive cycles.
5. Aging (`BLESS_INJ_AGE_EN`): hold one flit with `inj_ready` = 0 for 16 cycles -> age = 2; hold 200 cycles -> age = 15, not wrapping. Without the macro -> age stays 0.
6. With `level` = 2, enqueue and dequeue in the same cycle -> `level` stays 2 and the new entry lands at the tail.
